// File: rtl/roi_pkg.sv
// Shared types and defaults for the ROI frame buffer.
package roi_pkg;

    localparam int unsigned ROI_BIT_D = 8;

    typedef enum logic [1:0] {
        PASS  = 2'd0,
        DROP  = 2'd1,
        FLUSH = 2'd2
    } roi_state_e;

endpackage

// File: rtl/roi_fifo_mem.sv
// Simple dual-port RAM, DEPTH x WIDTH, registered read with write-first
// forwarding when the read and write addresses coincide.
module roi_fifo_mem #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        // Forwarding lets a beat written into an empty FIFO appear one cycle later.
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/roi_frame_buf.sv
// ROI frame FIFO with overflow drop/flush framing recovery.
// Optional per-frame statistics ports when ROI_FRAME_BUF_STATS_EN is defined.
module roi_frame_buf
    import roi_pkg::*;
#(
    parameter int unsigned BIT_D   = ROI_BIT_D,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned MAX_PXL = 480000
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic [BIT_D-1:0]         s_tdata_i,
    input  logic                     s_tvalid_i,
    input  logic                     s_tlast_i,
    output logic [BIT_D-1:0]         m_tdata_o,
    output logic                     m_tvalid_o,
    output logic                     m_tlast_o,
    input  logic                     m_tready_i,
    input  logic                     clr_i,
    output logic                     overflow_o,
`ifdef ROI_FRAME_BUF_STATS_EN
    output logic [$clog2(MAX_PXL):0] frame_len_o,
    output logic                     frame_done_o,
`endif
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(MAX_PXL) + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || MAX_PXL == 0) begin : g_param_check
        $error("roi_frame_buf: DEPTH must be a power of two >= 4 and MAX_PXL nonzero (CW=%0d)", CW);
    end

    roi_state_e       state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;

    logic             full;
    logic             rd;
    logic             we;
    logic             drop;
    logic [BIT_D:0]   wbeat;
    logic [BIT_D:0]   rbeat;

    assign full = (level_q == LW'(DEPTH));
    assign rd   = (level_q != '0) && m_tready_i;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= PASS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PASS:    if (s_tvalid_i && full) state_d = s_tlast_i ? FLUSH : DROP;
            DROP:    if (s_tvalid_i && s_tlast_i) state_d = full ? FLUSH : PASS;
            FLUSH:   if (!full) state_d = PASS;
            default: state_d = PASS;
        endcase
    end

    always_comb begin
        we    = 1'b0;
        drop  = 1'b0;
        wbeat = {s_tlast_i, s_tdata_i};
        unique case (state_q)
            PASS: begin
                if (s_tvalid_i) begin
                    we   = !full;
                    drop = full;
                end
            end
            DROP: begin
                if (s_tvalid_i) begin
                    if (s_tlast_i && !full) begin
                        we    = 1'b1;
                        wbeat = {1'b1, s_tdata_i};
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            FLUSH: begin
                drop  = s_tvalid_i;
                we    = !full;
                wbeat = {1'b1, {BIT_D{1'b0}}};
            end
            default: begin
                we = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (we && !rd) begin
            level_d = level_q + 1'b1;
        end else if (!we && rd) begin
            level_d = level_q - 1'b1;
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Reading at the next read pointer keeps the head entry registered at the output.
    roi_fifo_mem #(
        .WIDTH (BIT_D + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wbeat),
        .raddr_i (rd_ptr_d),
        .rdata_o (rbeat)
    );

    assign m_tdata_o  = rbeat[BIT_D-1:0];
    assign m_tlast_o  = rbeat[BIT_D];
    assign m_tvalid_o = (level_q != '0);
    assign overflow_o = ovf_q;
    assign level_o    = level_q;

`ifdef ROI_FRAME_BUF_STATS_EN
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] flen_q, flen_d;
    logic          done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        flen_d = flen_q;
        done_d = 1'b0;
        if (rd) begin
            if (m_tlast_o) begin
                flen_d = cnt_q + 1'b1;
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q  <= '0;
            flen_q <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flen_q <= flen_d;
            done_q <= done_d;
        end
    end

    assign frame_len_o  = flen_q;
    assign frame_done_o = done_q;
`endif

endmodule

// File: tb/tb_roi_frame_buf.sv
// Scoreboard bench for roi_frame_buf (DEPTH=4); stats checks follow ROI_FRAME_BUF_STATS_EN.
module tb_roi_frame_buf;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       arst;
    logic [7:0] s_tdata;
    logic       s_tvalid, s_tlast, m_tready, clr;
    logic [7:0] m_tdata;
    logic       m_tvalid, m_tlast, overflow;
    logic [2:0] level;
`ifdef ROI_FRAME_BUF_STATS_EN
    logic [10:0] frame_len;
    logic        frame_done;
`endif

    roi_frame_buf #(
        .BIT_D   (8),
        .DEPTH   (DEPTH),
        .MAX_PXL (1000)
    ) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .s_tdata_i    (s_tdata),
        .s_tvalid_i   (s_tvalid),
        .s_tlast_i    (s_tlast),
        .m_tdata_o    (m_tdata),
        .m_tvalid_o   (m_tvalid),
        .m_tlast_o    (m_tlast),
        .m_tready_i   (m_tready),
        .clr_i        (clr),
        .overflow_o   (overflow),
`ifdef ROI_FRAME_BUF_STATS_EN
        .frame_len_o  (frame_len),
        .frame_done_o (frame_done),
`endif
        .level_o      (level)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: FIFO occupancy, expected output beats, and framing recovery mode.
    int         mdl_lvl = 0;
    bit         mdl_ovf = 0;
    bit         mdl_dropping = 0;
    bit         mdl_flushing = 0;
    logic [8:0] exp_q[$];
    int         rd_cnt = 0;
    bit         pend_done = 0;
    int         pend_len = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (!arst) begin
            bit full, rd, wr, drop;
            logic [8:0] wb;
            full = (mdl_lvl == DEPTH);
            rd   = (mdl_lvl > 0) && m_tready;
            wr   = 0;
            drop = 0;
            wb   = {s_tlast, s_tdata};
            if (mdl_flushing) begin
                drop = s_tvalid;
                if (!full) begin
                    wr = 1;
                    wb = 9'h100;
                    mdl_flushing = 0;
                end
            end else if (mdl_dropping) begin
                if (s_tvalid) begin
                    if (s_tlast && !full) begin
                        wr = 1;
                        mdl_dropping = 0;
                    end else begin
                        drop = 1;
                        if (s_tlast) begin
                            mdl_dropping = 0;
                            mdl_flushing = 1;
                        end
                    end
                end
            end else if (s_tvalid) begin
                if (!full) wr = 1;
                else begin
                    drop = 1;
                    if (s_tlast) mdl_flushing = 1;
                    else mdl_dropping = 1;
                end
            end
            if (wr) exp_q.push_back(wb);
            mdl_lvl = mdl_lvl + int'(wr) - int'(rd);
            if (drop) mdl_ovf = 1;
            else if (clr) mdl_ovf = 0;
        end
    end

    always @(negedge clk) begin
        check("level", int'(level), mdl_lvl);
        check("tvalid", int'(m_tvalid), int'(mdl_lvl != 0));
        check("overflow", int'(overflow), int'(mdl_ovf));
`ifdef ROI_FRAME_BUF_STATS_EN
        check("frame_done", int'(frame_done), int'(pend_done));
        if (pend_done) check("frame_len", int'(frame_len), pend_len);
`endif
        pend_done = 0;
        if (m_tvalid && !arst) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL beat: got 0x%0h, expected no output beat at %0t", {m_tlast, m_tdata}, $time);
            end else begin
                check("beat", int'({m_tlast, m_tdata}), int'(exp_q[0]));
                if (m_tready) begin
                    logic [8:0] b;
                    b = exp_q.pop_front();
                    rd_cnt++;
                    if (b[8]) begin
                        pend_done = 1;
                        pend_len  = rd_cnt;
                        rd_cnt    = 0;
                    end
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [7:0] d, input bit l, input bit r, input bit c);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        m_tready = r;
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit r);
        repeat (n) drive(0, 8'h00, 0, r, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && level != 0; i++) drive(0, 8'h00, 0, 1, 0);
        check("drain_level", int'(level), 0);
    endtask

    task automatic do_reset();
        s_tvalid = 0;
        s_tlast  = 0;
        clr      = 0;
        arst     = 1;
        exp_q.delete();
        mdl_lvl = 0;
        mdl_ovf = 0;
        mdl_dropping = 0;
        mdl_flushing = 0;
        rd_cnt = 0;
        pend_done = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        arst = 0;
    endtask

    initial begin
        arst = 1;
        s_tdata = 0;
        s_tvalid = 0;
        s_tlast = 0;
        m_tready = 0;
        clr = 0;
        repeat (3) @(posedge clk);
        #1;
        arst = 0;

        // 10-pixel frame, downstream always ready
        for (int i = 1; i <= 10; i++) drive(1, 8'(i), i == 10, 1, 0);
        drain();

        // Stalled 6-beat frame: 4 stored, rest dropped, synthetic tlast appended
        for (int i = 1; i <= 6; i++) drive(1, 8'(8'h10 + i), i == 6, 0, 0);
        idle(3, 0);
        drain();
        drive(0, 8'h00, 0, 1, 1);

        // Full FIFO with simultaneous read and write
        for (int i = 1; i <= 4; i++) drive(1, 8'(8'h20 + i), 0, 0, 0);
        drive(1, 8'h25, 0, 1, 0);
        drive(1, 8'h26, 1, 1, 0);
        drain();
        drive(0, 8'h00, 0, 0, 1);

        // Ready toggling 1010..., 20 pixels
        for (int i = 0; i < 40; i++) drive(i % 2 == 0, 8'(8'h40 + i / 2), i == 38, i % 2 == 0, 0);
        drain();

        // Reset mid-frame, then a clean 3-pixel frame
        for (int i = 1; i <= 5; i++) drive(1, 8'(8'h60 + i), 0, 0, 0);
        do_reset();
        for (int i = 1; i <= 3; i++) drive(1, 8'(8'h70 + i), i == 3, 1, 0);
        drain();

        // Frames of 7 and 12 pixels for per-frame statistics
        do_reset();
        for (int i = 1; i <= 7; i++) drive(1, 8'(8'h80 + i), i == 7, 1, 0);
        for (int i = 1; i <= 12; i++) drive(1, 8'(8'h90 + i), i == 12, 1, 0);
        drain();
        idle(2, 1);

        // Randomized traffic with phases of varying downstream throughput
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            int rp;
            rp = (n / 250) % 4;
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) < rp + 1, $urandom_range(0, 31) == 0);
        end
        drive(1, 8'hEE, 1, 1, 0);
        idle(4, 1);
        drain();
        idle(2, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
